// File: rtl/score_pkg.sv
// Shared constants, converter state type and the digit-to-segment encoder
// for the four-digit score display.
package score_pkg;

   localparam int NUM_DIGITS = 4;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } cvt_state_t;

   function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
      logic [6:0] r;
      case (nibble)
         4'd0:    r = SEG_0;
         4'd1:    r = SEG_1;
         4'd2:    r = SEG_2;
         4'd3:    r = SEG_3;
         4'd4:    r = SEG_4;
         4'd5:    r = SEG_5;
         4'd6:    r = SEG_6;
         4'd7:    r = SEG_7;
         4'd8:    r = SEG_8;
         4'd9:    r = SEG_9;
         default: r = SEG_BLANK;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 converter: 16-bit binary to four BCD digits,
// one bit per clock, with a flag for values that do not fit in four digits.
module bin2bcd_seq
   import score_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        busy,
   output logic        done,
   output logic [15:0] bcd,
   output logic        ovf
);

   cvt_state_t  r_state;
   cvt_state_t  w_state_nxt;
   logic [31:0] r_sh;
   logic [15:0] r_bin;
   logic [3:0]  r_cnt;
   logic [15:0] r_bcd;
   logic        r_ovf;
   logic        r_done;
   logic [31:0] w_adj;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_SHIFT;
         ST_SHIFT: if (r_cnt == 4'd15) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Correct each BCD nibble before the shift so no nibble ever reaches 10
   always_comb begin
      w_adj = r_sh;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_sh[16+4*i +: 4] >= 4'd5)
            w_adj[16+4*i +: 4] = r_sh[16+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh   <= '0;
         r_bin  <= '0;
         r_cnt  <= '0;
         r_bcd  <= '0;
         r_ovf  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_sh  <= {16'd0, bin};
                  r_bin <= bin;
                  r_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               r_sh  <= {w_adj[30:0], 1'b0};
               r_cnt <= r_cnt + 4'd1;
            end
            ST_DONE: begin
               r_bcd <= r_sh[31:16];
               r_ovf <= (r_bin >= 16'd10000);
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign bcd  = r_bcd;
   assign ovf  = r_ovf;

endmodule

// File: rtl/score_display.sv
// Four-digit multiplexed seven-segment driver: captures score changes, converts
// them to BCD and scans the digits with registered active-low outputs.
module score_display
   import score_pkg::*;
#(
   parameter int REFRESH_BITS = 17,
   parameter int BLANK_LZ     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] score,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   logic [15:0]             r_last;
   logic [15:0]             r_digits;
   logic                    r_ovf;
   logic [REFRESH_BITS-1:0] r_rc;
   logic                    w_start;
   logic                    w_busy;
   logic                    w_done;
   logic [15:0]             w_bcd;
   logic                    w_ovf;
   logic [1:0]              w_sel;
   logic [3:0]              w_nib;
   logic [3:0]              w_lz;
   logic                    w_blank;
   logic [6:0]              w_seg;

   // A change seen while busy is simply re-detected once the converter idles
   assign w_start = (score != r_last) && !w_busy;

   bin2bcd_seq u_cvt (
      .clk   (clk),
      .rst_n (rst_n),
      .start (w_start),
      .bin   (score),
      .busy  (w_busy),
      .done  (w_done),
      .bcd   (w_bcd),
      .ovf   (w_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last   <= '0;
         r_digits <= '0;
         r_ovf    <= 1'b0;
         r_rc     <= '0;
      end else begin
         if (w_start) r_last <= score;
         if (w_done) begin
            r_digits <= w_bcd;
            r_ovf    <= w_ovf;
         end
         r_rc <= r_rc + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
      end
   end

   assign w_sel = r_rc[REFRESH_BITS-1 -: 2];
   assign w_nib = r_digits[{w_sel, 2'b00} +: 4];

   // w_lz[i]: digit i and every digit above it are zero
   always_comb begin
      w_lz    = '0;
      w_lz[3] = (r_digits[15:12] == 4'd0);
      w_lz[2] = w_lz[3] && (r_digits[11:8] == 4'd0);
      w_lz[1] = w_lz[2] && (r_digits[7:4] == 4'd0);
      w_lz[0] = w_lz[1] && (r_digits[3:0] == 4'd0);
   end

   assign w_blank = (BLANK_LZ != 0) && (w_sel != 2'd0) && w_lz[w_sel];

   always_comb begin
      w_seg = seg_encode(w_nib);
      if (r_ovf)        w_seg = SEG_DASH;
      else if (w_blank) w_seg = SEG_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an  <= 4'hF;
         seg <= SEG_BLANK;
      end else begin
         an  <= ~(4'b0001 << w_sel);
         seg <= w_seg;
      end
   end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: a decimal-arithmetic display model checked every
// cycle, plus literal digit patterns for each scenario.
module tb_score_display;

   localparam int RB  = 4;
   localparam int PER = 1 << (RB - 2);

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] score = 16'd0;
   logic [3:0]  an;
   logic [6:0]  seg;

   int checks   = 0;
   int failures = 0;

   score_display #(.REFRESH_BITS(RB), .BLANK_LZ(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .score (score),
      .an    (an),
      .seg   (seg)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] tb_seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Model: displayed decimal value, scan position, converter availability
   int         m_val, m_last, m_rc, m_edge, m_idle_at, m_pend_at, m_pend_val;
   int         m_sel, m_pw;
   logic [3:0] m_an  = 4'hF;
   logic [6:0] m_seg = 7'h7F;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_val = 0; m_last = 0; m_rc = 0; m_edge = 0;
         m_idle_at = 0; m_pend_at = -1; m_pend_val = 0;
         m_an = 4'hF; m_seg = 7'h7F;
      end else begin
         m_sel = (m_rc / PER) % 4;
         m_pw  = 1;
         for (int k = 0; k < m_sel; k++) m_pw = m_pw * 10;
         m_an = ~(4'b0001 << m_sel);
         if (m_val >= 10000)                m_seg = 7'b0111111;
         else if (m_sel != 0 && m_val < m_pw) m_seg = 7'b1111111;
         else                               m_seg = tb_seg((m_val / m_pw) % 10);
         m_rc = (m_rc + 1) % (1 << RB);
         if (m_edge == m_pend_at) m_val = m_pend_val;
         if (m_edge >= m_idle_at && int'(score) != m_last) begin
            m_last     = int'(score);
            m_pend_val = int'(score);
            m_pend_at  = m_edge + 18;
            m_idle_at  = m_edge + 18;
         end
         m_edge++;
      end
   end

   int shown = 0;
   always @(negedge clk) begin
      logic [10:0] exp_v;
      exp_v = rst_n ? {m_an, m_seg} : {4'hF, 7'h7F};
      checks++;
      if ({an, seg} !== exp_v) begin
         failures++;
         if (shown < 10) begin
            shown++;
            $display("FAIL cycle_model t=%0t an/seg got %h/%h expected %h/%h",
                     $time, an, seg, exp_v[10:7], exp_v[6:0]);
         end
      end
   end

   task automatic wait_digit(input logic [3:0] a, input logic [6:0] s, input string name);
      int n = 0;
      while (an !== a && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 40) begin
         failures++;
         $display("FAIL %s timeout waiting an=%h (last an=%h)", name, a, an);
      end else if (seg !== s) begin
         failures++;
         $display("FAIL %s seg got %h expected %h", name, seg, s);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (an !== 4'hF || seg !== 7'h7F) begin
         failures++;
         $display("FAIL reset an/seg got %h/%h expected f/7f", an, seg);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      wait_digit(4'hE, 7'h40, "rst_d0_zero");
      wait_digit(4'hD, 7'h7F, "rst_d1_blank");
      wait_digit(4'h7, 7'h7F, "rst_d3_blank");

      @(negedge clk); score = 16'd999;
      repeat (24) @(negedge clk);
      wait_digit(4'hE, 7'h10, "999_d0");
      wait_digit(4'hD, 7'h10, "999_d1");
      wait_digit(4'hB, 7'h10, "999_d2");
      wait_digit(4'h7, 7'h7F, "999_d3_blank");

      @(negedge clk); score = 16'd5;
      repeat (9) @(negedge clk);
      score = 16'd15;
      repeat (60) @(negedge clk);
      wait_digit(4'hE, 7'h12, "b2b_d0");
      wait_digit(4'hD, 7'h79, "b2b_d1");
      wait_digit(4'hB, 7'h7F, "b2b_d2_blank");

      score = 16'd12345;
      repeat (24) @(negedge clk);
      wait_digit(4'hE, 7'h3F, "ovf_d0");
      wait_digit(4'hD, 7'h3F, "ovf_d1");
      wait_digit(4'hB, 7'h3F, "ovf_d2");
      wait_digit(4'h7, 7'h3F, "ovf_d3");
      score = 16'd42;
      repeat (24) @(negedge clk);
      wait_digit(4'hE, 7'h24, "42_d0");
      wait_digit(4'hD, 7'h19, "42_d1");
      wait_digit(4'hB, 7'h7F, "42_d2_blank");
      wait_digit(4'h7, 7'h7F, "42_d3_blank");

      score = 16'd777;
      repeat (5) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (an !== 4'hF || seg !== 7'h7F) begin
         failures++;
         $display("FAIL midreset an/seg got %h/%h expected f/7f", an, seg);
      end
      score = 16'd310;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (24) @(negedge clk);
      wait_digit(4'hE, 7'h40, "310_d0");
      wait_digit(4'hD, 7'h79, "310_d1");
      wait_digit(4'hB, 7'h30, "310_d2");
      wait_digit(4'h7, 7'h7F, "310_d3_blank");

      repeat (3 * 4 * PER) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
